alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_pkg.sv | 45 ++++
 rtl/alu_ctrl_decode.sv | 48 ++++
 rtl/alu_exec_unit.sv | 71 +++++++
 tb/tb_alu_exec_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants for the execute stage: ALU_Op classes, funct codes, ALU control codes.
package alu_exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_RTYPE = 3'b010,
    OP_AND   = 3'b011,
    OP_OR    = 3'b100,
    OP_SLT   = 3'b101,
    OP_LUI   = 3'b110,
    OP_ADD2  = 3'b111
  } alu_op_e;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [3:0] {
    AC_AND  = 4'b0000,
    AC_OR   = 4'b0001,
    AC_ADD  = 4'b0010,
    AC_XOR  = 4'b0011,
    AC_NOR  = 4'b0100,
    AC_SLL  = 4'b0101,
    AC_SUB  = 4'b0110,
    AC_SLT  = 4'b0111,
    AC_SRL  = 4'b1000,
    AC_SRA  = 4'b1001,
    AC_SLTU = 4'b1010,
    AC_LUI  = 4'b1011
  } alu_ctrl_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU_Op/Funct decoder producing the ALU control code and jr flag.
module alu_ctrl_decode
  import alu_exec_pkg::*;
(
  input  logic [2:0] ALU_Op,
  input  logic [5:0] Funct,
  output logic [3:0] ALUctrl,
  output logic       JR_Signal
);

  alu_ctrl_e ctrl;

  always_comb begin
    ctrl      = AC_ADD;
    JR_Signal = 1'b0;
    case (alu_op_e'(ALU_Op))
      OP_SUB:   ctrl = AC_SUB;
      OP_AND:   ctrl = AC_AND;
      OP_OR:    ctrl = AC_OR;
      OP_SLT:   ctrl = AC_SLT;
      OP_LUI:   ctrl = AC_LUI;
      OP_RTYPE: begin
        case (Funct)
          FN_ADD, FN_ADDU: ctrl = AC_ADD;
          FN_SUB, FN_SUBU: ctrl = AC_SUB;
          FN_AND:          ctrl = AC_AND;
          FN_OR:           ctrl = AC_OR;
          FN_XOR:          ctrl = AC_XOR;
          FN_NOR:          ctrl = AC_NOR;
          FN_SLT:          ctrl = AC_SLT;
          FN_SLTU:         ctrl = AC_SLTU;
          FN_SLL:          ctrl = AC_SLL;
          FN_SRL:          ctrl = AC_SRL;
          FN_SRA:          ctrl = AC_SRA;
          FN_JR: begin
            ctrl      = AC_ADD;
            JR_Signal = 1'b1;
          end
          default:         ctrl = AC_ADD;
        endcase
      end
      default:  ctrl = AC_ADD;
    endcase
  end

  assign ALUctrl = ctrl;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU control decode, 32-bit ALU, branch target adder, one register stage.
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  ALU_Op,
  input  logic [5:0]  Funct,
  input  logic [4:0]  Shamt,
  input  logic [31:0] Read_Data_1,
  input  logic [31:0] Operand_B,
  input  logic [31:0] PC_Plus4,
  input  logic [31:0] Sign_Ext,
  output logic [31:0] Alu_Result,
  output logic        Zero,
  output logic [3:0]  ALUctrl,
  output logic        JR_Signal,
  output logic [31:0] Branch_Target
);

  logic [3:0]  ctrl_d;
  logic        jr_d;
  logic [31:0] result_d;
  logic [31:0] target_d;

  alu_ctrl_decode u_decode (
    .ALU_Op    (ALU_Op),
    .Funct     (Funct),
    .ALUctrl   (ctrl_d),
    .JR_Signal (jr_d)
  );

  always_comb begin
    result_d = '0;
    case (ctrl_d)
      AC_AND:  result_d = Read_Data_1 & Operand_B;
      AC_OR:   result_d = Read_Data_1 | Operand_B;
      AC_ADD:  result_d = Read_Data_1 + Operand_B;
      AC_XOR:  result_d = Read_Data_1 ^ Operand_B;
      AC_NOR:  result_d = ~(Read_Data_1 | Operand_B);
      AC_SLL:  result_d = Operand_B << Shamt;
      AC_SUB:  result_d = Read_Data_1 - Operand_B;
      AC_SLT:  result_d = {31'b0, $signed(Read_Data_1) < $signed(Operand_B)};
      AC_SRL:  result_d = Operand_B >> Shamt;
      AC_SRA:  result_d = $unsigned($signed(Operand_B) >>> Shamt);
      AC_SLTU: result_d = {31'b0, Read_Data_1 < Operand_B};
      AC_LUI:  result_d = {Operand_B[15:0], 16'h0000};
      default: result_d = '0;
    endcase
  end

  // Shifting the full word discards Sign_Ext[31:30], matching {Sign_Ext[29:0], 2'b00}.
  assign target_d = PC_Plus4 + (Sign_Ext << 2);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Alu_Result    <= '0;
      Zero          <= 1'b1;
      ALUctrl       <= AC_ADD;
      JR_Signal     <= 1'b0;
      Branch_Target <= '0;
    end else begin
      Alu_Result    <= result_d;
      Zero          <= (result_d == '0);
      ALUctrl       <= ctrl_d;
      JR_Signal     <= jr_d;
      Branch_Target <= target_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations queued on drive, popped one edge later.
module tb_alu_exec_unit;

  logic        Clock;
  logic        Reset;
  logic [2:0]  ALU_Op;
  logic [5:0]  Funct;
  logic [4:0]  Shamt;
  logic [31:0] Read_Data_1;
  logic [31:0] Operand_B;
  logic [31:0] PC_Plus4;
  logic [31:0] Sign_Ext;
  logic [31:0] Alu_Result;
  logic        Zero;
  logic [3:0]  ALUctrl;
  logic        JR_Signal;
  logic [31:0] Branch_Target;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  ctrl;
    logic        jr;
    logic [31:0] bt;
  } exp_t;

  exp_t sb[$];
  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  alu_exec_unit dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .ALU_Op        (ALU_Op),
    .Funct         (Funct),
    .Shamt         (Shamt),
    .Read_Data_1   (Read_Data_1),
    .Operand_B     (Operand_B),
    .PC_Plus4      (PC_Plus4),
    .Sign_Ext      (Sign_Ext),
    .Alu_Result    (Alu_Result),
    .Zero          (Zero),
    .ALUctrl       (ALUctrl),
    .JR_Signal     (JR_Signal),
    .Branch_Target (Branch_Target)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive at the falling edge, queue the expectation, then check after the next rising edge.
  task automatic apply(input string name, input logic [2:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] se,
                       input logic [31:0] res, input logic [3:0] ctrl, input logic jr,
                       input logic [31:0] bt);
    exp_t e;
    @(negedge Clock);
    ALU_Op = op; Funct = fn; Shamt = sh; Read_Data_1 = a; Operand_B = b;
    PC_Plus4 = pc; Sign_Ext = se;
    e.name = name; e.res = res; e.ctrl = ctrl; e.jr = jr; e.bt = bt;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    e = sb.pop_front();
    tests_run++;
    if (Alu_Result !== e.res) begin
      tests_failed++;
      $display("FAIL %s result: got %h expected %h", e.name, Alu_Result, e.res);
    end
    tests_run++;
    if (Zero !== (e.res == 32'h0)) begin
      tests_failed++;
      $display("FAIL %s zero: got %b expected %b", e.name, Zero, (e.res == 32'h0));
    end
    tests_run++;
    if (ALUctrl !== e.ctrl) begin
      tests_failed++;
      $display("FAIL %s ctrl: got %b expected %b", e.name, ALUctrl, e.ctrl);
    end
    tests_run++;
    if (JR_Signal !== e.jr) begin
      tests_failed++;
      $display("FAIL %s jr: got %b expected %b", e.name, JR_Signal, e.jr);
    end
    tests_run++;
    if (Branch_Target !== e.bt) begin
      tests_failed++;
      $display("FAIL %s target: got %h expected %h", e.name, Branch_Target, e.bt);
    end
  endtask

  task automatic check_reset_state(input string name);
    tests_run++;
    if (Alu_Result !== 32'h0 || Zero !== 1'b1 || ALUctrl !== 4'b0010 ||
        JR_Signal !== 1'b0 || Branch_Target !== 32'h0) begin
      tests_failed++;
      $display("FAIL %s: got res=%h z=%b ctrl=%b jr=%b bt=%h expected res=0 z=1 ctrl=0010 jr=0 bt=0",
               name, Alu_Result, Zero, ALUctrl, JR_Signal, Branch_Target);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    ALU_Op = 3'b001; Funct = 6'h0; Shamt = 5'h0; Read_Data_1 = 32'h5; Operand_B = 32'h3;
    PC_Plus4 = 32'h100; Sign_Ext = 32'h1;
    #1;
    check_reset_state("reset_initial");
    repeat (2) @(posedge Clock);
    #1;
    check_reset_state("reset_held_over_edges");
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_add_and_midreset();
    apply("add_overflow", 3'b000, 6'h00, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0,
          32'h80000000, 4'b0010, 1'b0, 32'h0);
    // Mid-cycle assertion: outputs clear immediately, not at the next edge.
    Reset = 1'b1;
    #1;
    sb.delete();
    check_reset_state("reset_mid_cycle");
    @(negedge Clock);
    Reset = 1'b0;
    apply("first_after_reset", 3'b111, 6'h00, 5'd0, 32'h10, 32'h20, 32'h0, 32'h0,
          32'h30, 4'b0010, 1'b0, 32'h0);
  endtask

  task automatic test_classes();
    apply("sub_zero", 3'b001, 6'h00, 5'd0, 32'h1234, 32'h1234, 32'h0, 32'h0,
          32'h0, 4'b0110, 1'b0, 32'h0);
    apply("and", 3'b011, 6'h00, 5'd0, 32'hF0F0FFFF, 32'h0FF0F00F, 32'h0, 32'h0,
          32'h00F0F00F, 4'b0000, 1'b0, 32'h0);
    apply("or", 3'b100, 6'h00, 5'd0, 32'hF0000000, 32'h0000000F, 32'h0, 32'h0,
          32'hF000000F, 4'b0001, 1'b0, 32'h0);
    apply("slt_class", 3'b101, 6'h00, 5'd0, 32'h80000000, 32'h0, 32'h0, 32'h0,
          32'h1, 4'b0111, 1'b0, 32'h0);
    apply("lui", 3'b110, 6'h00, 5'd0, 32'hDEAD0000, 32'hFFFFABCD, 32'h0, 32'h0,
          32'hABCD0000, 4'b1011, 1'b0, 32'h0);
  endtask

  task automatic test_rtype();
    apply("slt_signed", 3'b010, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0,
          32'h1, 4'b0111, 1'b0, 32'h0);
    apply("sltu", 3'b010, 6'b101011, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0,
          32'h0, 4'b1010, 1'b0, 32'h0);
    apply("sra", 3'b010, 6'b000011, 5'd4, 32'h12345678, 32'h80000000, 32'h0, 32'h0,
          32'hF8000000, 4'b1001, 1'b0, 32'h0);
    apply("srl", 3'b010, 6'b000010, 5'd4, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0,
          32'h08000000, 4'b1000, 1'b0, 32'h0);
    apply("sll31", 3'b010, 6'b000000, 5'd31, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0,
          32'h80000000, 4'b0101, 1'b0, 32'h0);
    apply("xor", 3'b010, 6'b100110, 5'd0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'h0,
          32'hF0F0F0F0, 4'b0011, 1'b0, 32'h0);
    apply("nor", 3'b010, 6'b100111, 5'd0, 32'hFF00FF00, 32'h00FF00F0, 32'h0, 32'h0,
          32'h0000000F, 4'b0100, 1'b0, 32'h0);
    apply("subu_wrap", 3'b010, 6'b100011, 5'd0, 32'h0, 32'h1, 32'h0, 32'h0,
          32'hFFFFFFFF, 4'b0110, 1'b0, 32'h0);
  endtask

  task automatic test_jr();
    apply("jr", 3'b010, 6'b001000, 5'd0, 32'h00400020, 32'h0, 32'h0, 32'h0,
          32'h00400020, 4'b0010, 1'b1, 32'h0);
    apply("jr_funct_not_rtype", 3'b000, 6'b001000, 5'd0, 32'h4, 32'h4, 32'h0, 32'h0,
          32'h8, 4'b0010, 1'b0, 32'h0);
    apply("unknown_funct", 3'b010, 6'b111111, 5'd0, 32'h1, 32'h2, 32'h0, 32'h0,
          32'h3, 4'b0010, 1'b0, 32'h0);
  endtask

  task automatic test_branch_target();
    apply("bt_negative", 3'b000, 6'h00, 5'd0, 32'h0, 32'h0, 32'h00400004, 32'hFFFFFFFF,
          32'h0, 4'b0010, 1'b0, 32'h00400000);
    apply("bt_positive", 3'b000, 6'h00, 5'd0, 32'h0, 32'h0, 32'h00400004, 32'h3,
          32'h0, 4'b0010, 1'b0, 32'h00400010);
    apply("bt_wrap", 3'b000, 6'h00, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h1,
          32'h0, 4'b0010, 1'b0, 32'h0);
  endtask

  // Several back-to-back random ADD/SUB operations; expected values from plain arithmetic.
  task automatic test_back_to_back();
    logic [31:0] a, b, pc, se;
    logic        sub;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; pc = $urandom; se = $urandom; sub = 1'($urandom_range(1));
      apply(sub ? "b2b_sub" : "b2b_add", sub ? 3'b001 : 3'b000, 6'h00, 5'd0, a, b, pc, se,
            sub ? a - b : a + b, sub ? 4'b0110 : 4'b0010, 1'b0,
            pc + {se[29:0], 2'b00});
    end
  endtask

  initial begin
    test_reset();
    test_add_and_midreset();
    test_classes();
    test_rtype();
    test_jr();
    test_branch_target();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
